multi_hand_datapath: RTL and testbench

- Parametrised successor to the two-hand baccarat datapath: holds NUM_HANDS hands of up to CARDS_PER_HAND cards each.
- Deals cards from an internal 1..13 card source over a 4-phase req/ack handshake, writing each card into the next free slot of the addressed hand.
- Keeps a registered baccarat score (sum mod 10) per hand and exposes a card read port for the controller FSM and the display logic.
- Single clock: the fast_clock card source of the previous generation is replaced by an internal counter on slow_clock.

---
 rtl/card_pkg.sv | 28 ++
 rtl/card_source.sv | 23 ++
 rtl/multi_hand_datapath.sv | 156 +++++++++++++++
 tb/tb_multi_hand_datapath.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/card_pkg.sv
// Shared types and arithmetic for the multi-hand baccarat datapath:
// card encoding, baccarat point value and the mod-10 score adder.
package card_pkg;

  typedef logic [3:0] card_t;

  localparam card_t CARD_MIN  = 4'd1;
  localparam card_t CARD_MAX  = 4'd13;
  localparam card_t CARD_NONE = 4'd0;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } deal_state_e;

  // Ace..9 score face value; tens, faces and any out-of-range value score 0.
  function automatic logic [3:0] card_pts(input card_t card);
    return ((card >= 4'd1) && (card <= 4'd9)) ? card : 4'd0;
  endfunction

  // Both operands are 0..9, so one conditional subtract of 10 suffices.
  function automatic logic [3:0] add_mod10(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum >= 5'd10) ? 4'(sum - 5'd10) : sum[3:0];
  endfunction

endpackage

// File: rtl/card_source.sv
// Free-running 1..13 card generator; sits at 1 during reset and steps every clock.
module card_source
  import card_pkg::*;
(
  input  logic  slow_clock,
  input  logic  resetb,
  output card_t card
);

  card_t card_q, card_d;

  always_comb begin
    card_d = (card_q == CARD_MAX) ? CARD_MIN : card_q + 4'd1;
  end

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) card_q <= CARD_MIN;
    else         card_q <= card_d;
  end

  assign card = card_q;

endmodule

// File: rtl/multi_hand_datapath.sv
// NUM_HANDS x CARDS_PER_HAND card store with 4-phase deal handshake,
// per-hand baccarat scores and a combinational card read port.
module multi_hand_datapath
  import card_pkg::*;
#(
  parameter int NUM_HANDS      = 2,
  parameter int CARDS_PER_HAND = 3,
  parameter int HW             = (NUM_HANDS > 2) ? $clog2(NUM_HANDS) : 1,
  parameter int SW             = $clog2(CARDS_PER_HAND)
) (
  input  logic                            slow_clock,
  input  logic                            resetb,
  input  logic                            clear,
  input  logic                            deal_req,
  input  logic [HW-1:0]                   deal_hand,
  input  logic                            force_en,
  input  logic [3:0]                      force_card,
  output logic                            deal_ack,
  output logic                            deal_err,
  output logic [3:0]                      deal_card,
  output logic [NUM_HANDS*SW+NUM_HANDS-1:0] card_count,
  output logic [NUM_HANDS-1:0]            hand_full,
  output logic [NUM_HANDS*4-1:0]          score_out,
  input  logic [HW-1:0]                   rd_hand,
  input  logic [SW-1:0]                   rd_slot,
  output logic [3:0]                      rd_card
);

  localparam int CW = SW + 1;

  card_t       src_card;
  card_t       card_in;
  deal_state_e state_q, state_d;
  logic        deal_err_q, deal_err_d;
  card_t       deal_card_q, deal_card_d;
  logic        full_sel;
  logic        hand_ok;
  logic        take_req;
  logic        accept;
  logic [NUM_HANDS*CARDS_PER_HAND*4-1:0] cards_flat;

  card_source u_src (
    .slow_clock (slow_clock),
    .resetb     (resetb),
    .card       (src_card)
  );

  assign card_in = force_en ? force_card : src_card;

  always_comb begin
    full_sel = 1'b0;
    for (int h = 0; h < NUM_HANDS; h++) begin
      if (int'(deal_hand) == h) full_sel = hand_full[h];
    end
  end

  // A request is consumed only once per pulse: it is looked at in IDLE alone.
  assign hand_ok  = (int'(deal_hand) < NUM_HANDS) && !full_sel;
  assign take_req = (state_q == ST_IDLE) && deal_req && !clear;
  assign accept   = take_req && hand_ok;

  always_comb begin
    state_d     = state_q;
    deal_err_d  = take_req && !hand_ok;
    deal_card_d = deal_card_q;
    if (clear) begin
      state_d     = ST_IDLE;
      deal_card_d = CARD_NONE;
    end else begin
      case (state_q)
        ST_IDLE: if (deal_req)  state_d = ST_ACK;
        ST_ACK:  if (!deal_req) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
      if (accept) deal_card_d = card_in;
    end
  end

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      state_q     <= ST_IDLE;
      deal_err_q  <= 1'b0;
      deal_card_q <= CARD_NONE;
    end else begin
      state_q     <= state_d;
      deal_err_q  <= deal_err_d;
      deal_card_q <= deal_card_d;
    end
  end

  assign deal_ack  = (state_q == ST_ACK);
  assign deal_err  = deal_err_q;
  assign deal_card = deal_card_q;

  genvar gi, gs;
  generate
    for (gi = 0; gi < NUM_HANDS; gi++) begin : g_hand
      logic [CW-1:0] count_q, count_d;
      logic [3:0]    score_q, score_d;
      card_t         slot_q [CARDS_PER_HAND];
      card_t         slot_d [CARDS_PER_HAND];
      logic          hit;

      assign hit = accept && (deal_hand == HW'(gi));

      always_comb begin
        count_d = count_q;
        score_d = score_q;
        slot_d  = slot_q;
        if (clear) begin
          count_d = '0;
          score_d = '0;
          for (int s = 0; s < CARDS_PER_HAND; s++) slot_d[s] = CARD_NONE;
        end else if (hit) begin
          count_d = count_q + 1'b1;
          score_d = add_mod10(score_q, card_pts(card_in));
          for (int s = 0; s < CARDS_PER_HAND; s++) begin
            if (int'(count_q) == s) slot_d[s] = card_in;
          end
        end
      end

      always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
          count_q <= '0;
          score_q <= '0;
          for (int s = 0; s < CARDS_PER_HAND; s++) slot_q[s] <= CARD_NONE;
        end else begin
          count_q <= count_d;
          score_q <= score_d;
          for (int s = 0; s < CARDS_PER_HAND; s++) slot_q[s] <= slot_d[s];
        end
      end

      assign card_count[gi*CW +: CW] = count_q;
      assign score_out[gi*4 +: 4]    = score_q;
      assign hand_full[gi]           = (count_q == CW'(CARDS_PER_HAND));

      for (gs = 0; gs < CARDS_PER_HAND; gs++) begin : g_slot
        assign cards_flat[(gi*CARDS_PER_HAND+gs)*4 +: 4] = slot_q[gs];
      end
    end
  endgenerate

  // Unmatched (out-of-range) selects fall through to 0.
  always_comb begin
    rd_card = CARD_NONE;
    for (int h = 0; h < NUM_HANDS; h++) begin
      for (int s = 0; s < CARDS_PER_HAND; s++) begin
        if (int'(rd_hand) == h && int'(rd_slot) == s)
          rd_card = cards_flat[(h*CARDS_PER_HAND+s)*4 +: 4];
      end
    end
  end

endmodule

// File: tb/tb_multi_hand_datapath.sv
// Directed bench for multi_hand_datapath with 3 hands of 3 cards:
// a vector table for deals/rejects plus sequences for hold, clear and reset.
module tb_multi_hand_datapath;

  localparam int NH  = 3;
  localparam int CPH = 3;
  localparam int HW  = 2;
  localparam int SW  = 2;

  logic              clk = 1'b0;
  logic              resetb = 1'b0;
  logic              clear = 1'b0;
  logic              deal_req = 1'b0;
  logic [HW-1:0]     deal_hand = '0;
  logic              force_en = 1'b0;
  logic [3:0]        force_card = '0;
  logic              deal_ack;
  logic              deal_err;
  logic [3:0]        deal_card;
  logic [NH*(SW+1)-1:0] card_count;
  logic [NH-1:0]     hand_full;
  logic [NH*4-1:0]   score_out;
  logic [HW-1:0]     rd_hand = '0;
  logic [SW-1:0]     rd_slot = '0;
  logic [3:0]        rd_card;

  int errors = 0;
  int checks = 0;

  multi_hand_datapath #(.NUM_HANDS(NH), .CARDS_PER_HAND(CPH)) dut (
    .slow_clock (clk),
    .resetb     (resetb),
    .clear      (clear),
    .deal_req   (deal_req),
    .deal_hand  (deal_hand),
    .force_en   (force_en),
    .force_card (force_card),
    .deal_ack   (deal_ack),
    .deal_err   (deal_err),
    .deal_card  (deal_card),
    .card_count (card_count),
    .hand_full  (hand_full),
    .score_out  (score_out),
    .rd_hand    (rd_hand),
    .rd_slot    (rd_slot),
    .rd_card    (rd_card)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] hand;
    logic [3:0] card;
    logic       exp_err;
    logic [3:0] exp_dcard;
    logic [1:0] chk_hand;
    logic [3:0] exp_score;
    logic [2:0] exp_count;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  function automatic logic [3:0] score_of(input int h);
    return score_out[h*4 +: 4];
  endfunction

  function automatic logic [2:0] count_of(input int h);
    return card_count[h*(SW+1) +: SW+1];
  endfunction

  task automatic deal(input logic fe, input logic [3:0] c, input logic [1:0] h);
    @(negedge clk);
    force_en = fe; force_card = c; deal_hand = h; deal_req = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic drop_req();
    @(negedge clk);
    deal_req = 1'b0;
    @(posedge clk); #1;
    chk("ack_low_after_drop", 32'(deal_ack), 32'd0);
    chk("err_low_after_drop", 32'(deal_err), 32'd0);
  endtask

  task automatic rd(input logic [1:0] h, input logic [1:0] s, input logic [3:0] exp, input string name);
    rd_hand = h; rd_slot = s; #1;
    chk(name, 32'(rd_card), 32'(exp));
  endtask

  initial begin
    vecs[0] = '{2'd1, 4'd9,  1'b0, 4'd9,  2'd1, 4'd9, 3'd1};
    vecs[1] = '{2'd1, 4'd5,  1'b0, 4'd5,  2'd1, 4'd4, 3'd2};
    vecs[2] = '{2'd1, 4'd13, 1'b0, 4'd13, 2'd1, 4'd4, 3'd3};
    vecs[3] = '{2'd1, 4'd7,  1'b1, 4'd13, 2'd1, 4'd4, 3'd3};
    vecs[4] = '{2'd3, 4'd2,  1'b1, 4'd13, 2'd0, 4'd4, 3'd1};
    vecs[5] = '{2'd0, 4'd14, 1'b0, 4'd14, 2'd0, 4'd4, 3'd2};
    vecs[6] = '{2'd0, 4'd8,  1'b0, 4'd8,  2'd0, 4'd2, 3'd3};
    vecs[7] = '{2'd2, 4'd0,  1'b0, 4'd0,  2'd2, 4'd0, 3'd1};

    // Reset state
    #12;
    chk("rst_ack", 32'(deal_ack), 32'd0);
    chk("rst_err", 32'(deal_err), 32'd0);
    chk("rst_dcard", 32'(deal_card), 32'd0);
    chk("rst_count", 32'(card_count), 32'd0);
    chk("rst_score", 32'(score_out), 32'd0);
    rd(2'd1, 2'd1, 4'd0, "rst_rd_card");

    // Release, then the source reads 1,2,3,4 at edges 0..3
    @(negedge clk); resetb = 1'b1;
    repeat (3) @(posedge clk);
    deal(1'b0, 4'd0, 2'd0);
    chk("src_deal_card", 32'(deal_card), 32'd4);
    chk("src_score0", 32'(score_of(0)), 32'd4);
    chk("src_count0", 32'(count_of(0)), 32'd1);
    chk("src_ack", 32'(deal_ack), 32'd1);
    @(posedge clk); #1;
    chk("src_ack_held", 32'(deal_ack), 32'd1);
    drop_req();

    // Table of forced deals and rejects
    for (int i = 0; i < 8; i++) begin
      deal(1'b1, vecs[i].card, vecs[i].hand);
      $display("vec %0d: hand=%0d card=%0d", i, vecs[i].hand, vecs[i].card);
      chk($sformatf("v%0d_ack", i), 32'(deal_ack), 32'd1);
      chk($sformatf("v%0d_err", i), 32'(deal_err), 32'(vecs[i].exp_err));
      chk($sformatf("v%0d_dcard", i), 32'(deal_card), 32'(vecs[i].exp_dcard));
      chk($sformatf("v%0d_score", i), 32'(score_of(int'(vecs[i].chk_hand))), 32'(vecs[i].exp_score));
      chk($sformatf("v%0d_count", i), 32'(count_of(int'(vecs[i].chk_hand))), 32'(vecs[i].exp_count));
      drop_req();
    end
    chk("hand_full_a", 32'(hand_full), 32'b011);
    rd(2'd1, 2'd2, 4'd13, "rd_1_2");
    rd(2'd1, 2'd0, 4'd9,  "rd_1_0");
    rd(2'd0, 2'd1, 4'd14, "rd_0_1");
    rd(2'd3, 2'd0, 4'd0,  "rd_bad_hand");
    rd(2'd0, 2'd3, 4'd0,  "rd_bad_slot");

    // Held request deals exactly one card
    deal(1'b1, 4'd6, 2'd2);
    chk("hold_count_first", 32'(count_of(2)), 32'd2);
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      chk($sformatf("hold_count_c%0d", i), 32'(count_of(2)), 32'd2);
      chk($sformatf("hold_ack_c%0d", i), 32'(deal_ack), 32'd1);
    end
    drop_req();
    deal(1'b1, 4'd3, 2'd2);
    chk("rehold_count", 32'(count_of(2)), 32'd3);
    chk("rehold_score", 32'(score_of(2)), 32'd9);
    chk("hand_full_b", 32'(hand_full), 32'b111);
    drop_req();

    // Clear wins over a simultaneous deal; held request deals next edge
    @(negedge clk);
    clear = 1'b1; deal_req = 1'b1; force_en = 1'b1; force_card = 4'd7; deal_hand = 2'd0;
    @(posedge clk); #1;
    chk("clr_count", 32'(card_count), 32'd0);
    chk("clr_score", 32'(score_out), 32'd0);
    chk("clr_dcard", 32'(deal_card), 32'd0);
    chk("clr_ack", 32'(deal_ack), 32'd0);
    rd(2'd1, 2'd2, 4'd0, "clr_rd_1_2");
    @(negedge clk); clear = 1'b0;
    @(posedge clk); #1;
    chk("post_clr_count0", 32'(count_of(0)), 32'd1);
    chk("post_clr_score0", 32'(score_of(0)), 32'd7);
    chk("post_clr_ack", 32'(deal_ack), 32'd1);
    drop_req();

    // Asynchronous reset while in ACK
    deal(1'b1, 4'd2, 2'd1);
    chk("pre_rst_ack", 32'(deal_ack), 32'd1);
    chk("pre_rst_score1", 32'(score_of(1)), 32'd2);
    #2 resetb = 1'b0; force_en = 1'b0;
    #1;
    chk("async_rst_ack", 32'(deal_ack), 32'd0);
    chk("async_rst_score", 32'(score_out), 32'd0);
    chk("async_rst_count", 32'(card_count), 32'd0);
    @(negedge clk); resetb = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_dcard", 32'(deal_card), 32'd1);
    chk("post_rst_score1", 32'(score_of(1)), 32'd1);
    chk("post_rst_count1", 32'(count_of(1)), 32'd1);
    chk("post_rst_ack", 32'(deal_ack), 32'd1);
    drop_req();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
